// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_pkg
//  Description : Shared definitions for the instruction fetch unit. Holds the
//                opcode encodings, the instruction field bit positions and the
//                fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    // Opcode encodings carried in instr[15:13]
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_BEQ  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_ORI  = 3'b111;

    // Field bit positions. rd and imm overlap on purpose: R-type uses rd,
    // I-type uses imm, and decode picks whichever applies.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int RS_MSB     = 12;
    localparam int RS_LSB     = 10;
    localparam int RT_MSB     = 9;
    localparam int RT_LSB     = 7;
    localparam int RD_MSB     = 6;
    localparam int RD_LSB     = 4;
    localparam int IMM_MSB    = 6;
    localparam int IMM_LSB    = 0;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage : instr_fetch_unit_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Instruction-memory read bus between the fetch unit (master)
//                and the instruction memory (slave).
//                  mem_req   : read request, held until mem_ack
//                  mem_addr  : word address of the request
//                  mem_ack   : mem_rdata valid this cycle
//                  mem_rdata : instruction word
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface : instr_fetch_unit_if
`default_nettype wire

// File: rtl/instr_field_split.sv
`default_nettype none
// ============================================================================
//  Module      : instr_field_split
//  Description : Purely combinational split of a 16-bit instruction word into
//                its decode fields.
//  Ports       : i_instr  - instruction word
//                o_opcode - instr[15:13]
//                o_rs     - instr[12:10]
//                o_rt     - instr[9:7]
//                o_rd     - instr[6:4]
//                o_imm    - instr[6:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_field_split
    import instr_fetch_unit_pkg::*;
(
    input  wire logic [15:0] i_instr,
    output logic      [2:0]  o_opcode,
    output logic      [2:0]  o_rs,
    output logic      [2:0]  o_rt,
    output logic      [2:0]  o_rd,
    output logic      [6:0]  o_imm
);
    assign o_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign o_rs     = i_instr[RS_MSB:RS_LSB];
    assign o_rt     = i_instr[RT_MSB:RT_LSB];
    assign o_rd     = i_instr[RD_MSB:RD_LSB];
    assign o_imm    = i_instr[IMM_MSB:IMM_LSB];
endmodule : instr_field_split
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Three-state instruction fetch unit. Issues a read to
//                instruction memory, waits for the acknowledge, then holds the
//                instruction for decode until it is accepted. A branch
//                redirect from execute restarts fetch at the target address.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                bus (master)        - instruction-memory read bus
//                br_taken, br_target - redirect request and address
//                id_ready            - decode accepts the held instruction
//                if_valid            - held instruction and fields are valid
//                if_instr, if_pc     - held instruction and its address
//                opcode/rs/rt/rd/imm - field slices of if_instr
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    instr_fetch_unit_if.master      bus,
    input  wire logic               br_taken,
    input  wire logic [PC_W-1:0]    br_target,
    input  wire logic               id_ready,
    output logic                    if_valid,
    output logic      [INSTR_W-1:0] if_instr,
    output logic      [PC_W-1:0]    if_pc,
    output logic      [2:0]         opcode,
    output logic      [2:0]         rs,
    output logic      [2:0]         rt,
    output logic      [2:0]         rd,
    output logic      [6:0]         imm
);
    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_mem_req;
    logic [PC_W-1:0]    r_mem_addr;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [PC_W-1:0]    r_if_pc;

    // All outputs are registered. FETCH is the cycle in which the request is
    // launched, so mem_req becomes visible on the edge that leaves FETCH;
    // this is what gives the two-cycle FETCH-to-if_valid latency and the
    // three-cycle accept period with a zero-wait memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (br_taken) begin
            // Redirect wins over everything: a same-cycle mem_ack is dropped
            // and a same-cycle id_ready does not advance pc to pc+1.
            r_pc       <= br_target;
            r_mem_req  <= 1'b0;
            r_if_valid <= 1'b0;
            r_state    <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= r_pc;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // mem_req/mem_addr hold until the acknowledge arrives
                    if (bus.mem_ack) begin
                        r_if_instr <= bus.mem_rdata;
                        r_if_pc    <= r_pc;
                        r_pc       <= r_pc + c_PC_ONE;  // wraps silently
                        r_if_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        r_if_valid <= 1'b0;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_mem_req  <= 1'b0;
                    r_if_valid <= 1'b0;
                    r_state    <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign if_valid     = r_if_valid;
    assign if_instr     = r_if_instr;
    assign if_pc        = r_if_pc;

    instr_field_split u_field_split (
        .i_instr  (r_if_instr),
        .o_opcode (opcode),
        .o_rs     (rs),
        .o_rt     (rt),
        .o_rd     (rd),
        .o_imm    (imm)
    );
endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit. Each task
//                drives one scenario and checks the outputs at fixed cycles,
//                sampled one time unit after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        br_taken  = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic        id_ready  = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic [2:0]  opcode, rs, rt, rd;
    logic [6:0]  imm;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_if ();

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .br_taken  (br_taken),
        .br_target (br_target),
        .id_ready  (id_ready),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus_if.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus_if.mem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instr !== 16'h0000) begin n_err++; $display("FAIL reset_if_instr: got %h want 0000", if_instr); end
        n_cmp++; if (if_pc !== 8'h00) begin n_err++; $display("FAIL reset_if_pc: got %h want 00", if_pc); end
        rst_n = 1'b1;
        tick();
        // first edge after release raises the request at RESET_PC
        n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", bus_if.mem_req); end
        n_cmp++; if (bus_if.mem_addr !== 8'h00) begin n_err++; $display("FAIL first_addr: got %h want 00", bus_if.mem_addr); end
    endtask

    task automatic test_sequential_fetch();
        logic [15:0] words [3];
        logic [2:0]  ops   [3];
        words[0] = 16'h0000; ops[0] = OP_ADD;
        words[1] = 16'h2000; ops[1] = OP_SUB;
        words[2] = 16'h4000; ops[2] = OP_BEQ;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL seq_req[%0d]: got %b want 1", i, bus_if.mem_req); end
            n_cmp++; if (bus_if.mem_addr !== 8'(i)) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus_if.mem_addr, 8'(i)); end
            bus_if.mem_ack = 1'b1; bus_if.mem_rdata = words[i]; id_ready = 1'b1;
            tick();
            bus_if.mem_ack = 1'b0;
            n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, if_valid); end
            n_cmp++; if (if_instr !== words[i]) begin n_err++; $display("FAIL seq_instr[%0d]: got %h want %h", i, if_instr, words[i]); end
            n_cmp++; if (if_pc !== 8'(i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, if_pc, 8'(i)); end
            n_cmp++; if (opcode !== ops[i]) begin n_err++; $display("FAIL seq_opcode[%0d]: got %b want %b", i, opcode, ops[i]); end
            n_cmp++; if (bus_if.mem_req !== 1'b0) begin n_err++; $display("FAIL seq_hold_req[%0d]: got %b want 0", i, bus_if.mem_req); end
            tick();
            n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL seq_accept[%0d]: got %b want 0", i, if_valid); end
            tick();
        end
        id_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        // currently WAIT at address 3
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hC47F;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (rs !== 3'd1) begin n_err++; $display("FAIL hold_rs: got %0d want 1", rs); end
        n_cmp++; if (rt !== 3'd0) begin n_err++; $display("FAIL hold_rt: got %0d want 0", rt); end
        n_cmp++; if (rd !== 3'd7) begin n_err++; $display("FAIL hold_rd: got %0d want 7", rd); end
        n_cmp++; if (if_pc !== 8'h03) begin n_err++; $display("FAIL hold_pc: got %h want 03", if_pc); end
        repeat (5) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid: got %b want 1", if_valid); end
            n_cmp++; if (if_instr !== 16'hC47F) begin n_err++; $display("FAIL hold_instr: got %h want c47f", if_instr); end
            n_cmp++; if (opcode !== 3'b110) begin n_err++; $display("FAIL hold_opcode: got %b want 110", opcode); end
            n_cmp++; if (imm !== 7'h7F) begin n_err++; $display("FAIL hold_imm: got %h want 7f", imm); end
            n_cmp++; if (bus_if.mem_req !== 1'b0) begin n_err++; $display("FAIL hold_no_req: got %b want 0", bus_if.mem_req); end
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b want 0", if_valid); end
        tick();
        n_cmp++; if (bus_if.mem_addr !== 8'h04) begin n_err++; $display("FAIL hold_next_addr: got %h want 04", bus_if.mem_addr); end
    endtask

    task automatic test_branch();
        // branch in the same cycle as mem_ack: data must be dropped
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'h1234;
        br_taken = 1'b1; br_target = 8'h40;
        tick();
        bus_if.mem_ack = 1'b0; br_taken = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL br_ack_valid: got %b want 0", if_valid); end
        n_cmp++; if (bus_if.mem_req !== 1'b0) begin n_err++; $display("FAIL br_ack_req_drop: got %b want 0", bus_if.mem_req); end
        n_cmp++; if (if_instr !== 16'hC47F) begin n_err++; $display("FAIL br_ack_discard: got %h want c47f", if_instr); end
        tick();
        n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL br_target_req: got %b want 1", bus_if.mem_req); end
        n_cmp++; if (bus_if.mem_addr !== 8'h40) begin n_err++; $display("FAIL br_target_addr: got %h want 40", bus_if.mem_addr); end
        // branch together with id_ready in HOLD: no fetch of pc+1
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hA000;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (if_pc !== 8'h40) begin n_err++; $display("FAIL br_hold_pc: got %h want 40", if_pc); end
        id_ready = 1'b1; br_taken = 1'b1; br_target = 8'hFE;
        tick();
        id_ready = 1'b0; br_taken = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL br_ready_valid: got %b want 0", if_valid); end
        tick();
        n_cmp++; if (bus_if.mem_addr !== 8'hFE) begin n_err++; $display("FAIL br_ready_addr: got %h want fe", bus_if.mem_addr); end
    endtask

    task automatic test_pc_wrap();
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'h8000; id_ready = 1'b1;
        tick();
        bus_if.mem_ack = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus_if.mem_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_addr_ff: got %h want ff", bus_if.mem_addr); end
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hA000;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (if_pc !== 8'hFF) begin n_err++; $display("FAIL wrap_if_pc: got %h want ff", if_pc); end
        tick();
        tick();
        id_ready = 1'b0;
        n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req: got %b want 1", bus_if.mem_req); end
        n_cmp++; if (bus_if.mem_addr !== 8'h00) begin n_err++; $display("FAIL wrap_addr_00: got %h want 00", bus_if.mem_addr); end
    endtask

    task automatic test_reset_mid_state();
        // move pc away from RESET_PC so the post-reset address is meaningful
        br_taken = 1'b1; br_target = 8'h55;
        tick();
        br_taken = 1'b0;
        tick();
        n_cmp++; if (bus_if.mem_addr !== 8'h55) begin n_err++; $display("FAIL rst_pre_addr: got %h want 55", bus_if.mem_addr); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_wait_req: got %b want 0", bus_if.mem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_wait_valid: got %b want 0", if_valid); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL rst_rel_req: got %b want 1", bus_if.mem_req); end
        n_cmp++; if (bus_if.mem_addr !== 8'h00) begin n_err++; $display("FAIL rst_rel_addr: got %h want 00", bus_if.mem_addr); end
        // reset during HOLD
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'h6000;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL rst_hold_pre: got %b want 1", if_valid); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instr !== 16'h0000) begin n_err++; $display("FAIL rst_hold_instr: got %h want 0000", if_instr); end
        n_cmp++; if (opcode !== 3'b000) begin n_err++; $display("FAIL rst_hold_opcode: got %b want 000", opcode); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_delayed_ack();
        // WAIT at address 0, memory slow by 4 cycles
        repeat (4) begin
            tick();
            n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL dly_req: got %b want 1", bus_if.mem_req); end
            n_cmp++; if (bus_if.mem_addr !== 8'h00) begin n_err++; $display("FAIL dly_addr: got %h want 00", bus_if.mem_addr); end
            n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL dly_valid_early: got %b want 0", if_valid); end
        end
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hE123;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL dly_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_instr !== 16'hE123) begin n_err++; $display("FAIL dly_instr: got %h want e123", if_instr); end
        n_cmp++; if (opcode !== OP_ORI) begin n_err++; $display("FAIL dly_opcode: got %b want 111", opcode); end
        // stray acks in HOLD and FETCH are ignored
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'h5555;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (if_instr !== 16'hE123) begin n_err++; $display("FAIL stray_hold_instr: got %h want e123", if_instr); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'h7777;
        tick();
        bus_if.mem_ack = 1'b0;
        n_cmp++; if (bus_if.mem_addr !== 8'h01) begin n_err++; $display("FAIL stray_fetch_addr: got %h want 01", bus_if.mem_addr); end
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stray_fetch_valid: got %b want 0", if_valid); end
        n_cmp++; if (bus_if.mem_req !== 1'b1) begin n_err++; $display("FAIL stray_fetch_req: got %b want 1", bus_if.mem_req); end
    endtask

    initial begin
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 16'h0000;
        test_reset();
        test_sequential_fetch();
        test_hold_stall();
        test_branch();
        test_pc_wrap();
        test_reset_mid_state();
        test_delayed_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_instr_fetch_unit
`default_nettype wire
